// File: rtl/fx_pkg.sv
// Shared types and helpers for the fixed-point divide sequencer.
// sat_signed works on a 64-bit magnitude so any word width up to 32 can reuse it.
package fx_pkg;
  localparam int QW   = 32;
  localparam int QF   = 16;
  localparam int MAXW = 64;

  localparam logic [QW-1:0] Q_MAX_POS = 32'h7FFF_FFFF;
  localparam logic [QW-1:0] Q_MIN_NEG = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_MUL,
    ST_OUT
  } state_e;

  // Clamp a magnitude into a w-bit signed range and apply the sign.
  // The caller keeps only the low w bits of the result.
  function automatic logic [MAXW-1:0] sat_signed(input logic [MAXW-1:0] mag,
                                                 input logic            neg,
                                                 input int unsigned     w);
    logic [MAXW-1:0] lim;
    lim = 64'd1 << (w - 1);
    if (!neg) sat_signed = (mag >= lim) ? (lim - 64'd1) : mag;
    else      sat_signed = (mag > lim)  ? lim : (~mag + 64'd1);
  endfunction
endpackage

// File: rtl/fx_div_seq_if.sv
// Operand/result handshakes plus the reciprocal-unit request channel.
// slave is the sequencer's view, master is the environment's view.
interface fx_div_seq_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num_in;
  logic [W-1:0] den_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quo_out;
  logic         out_err;
  logic         recip_start;
  logic [W-1:0] recip_x;
  logic         recip_done;
  logic [W-1:0] recip_inv;
  logic         recip_invalid;

  modport slave (
    input  in_valid, num_in, den_in, out_ready, recip_done, recip_inv, recip_invalid,
    output in_ready, out_valid, quo_out, out_err, recip_start, recip_x
  );

  modport master (
    output in_valid, num_in, den_in, out_ready, recip_done, recip_inv, recip_invalid,
    input  in_ready, out_valid, quo_out, out_err, recip_start, recip_x
  );
endinterface

// File: rtl/fx_sat_mul.sv
// Magnitude times reciprocal, QF rescale by truncation, signed saturation.
// Purely combinational; the sequencer registers the result.
module fx_sat_mul
  import fx_pkg::*;
#(
  parameter int W = 32,
  parameter int F = 16
) (
  input  logic [W-1:0] num_abs,
  input  logic [W-1:0] inv,
  input  logic         neg,
  output logic [W-1:0] result
);
  logic [2*W-1:0] prod;
  logic [2*W-1:0] q;

  always_comb begin
    prod   = {{W{1'b0}}, num_abs} * {{W{1'b0}}, inv};
    q      = prod >> F;
    result = W'(sat_signed(MAXW'(q), neg, W));
  end
endmodule

// File: rtl/fx_div_seq.sv
// Signed QF divider built on an external reciprocal unit: num/den = |num|*(1/|den|)
// with sign fix-up, divide-by-zero/overflow handling and a done timeout.
module fx_div_seq
  import fx_pkg::*;
#(
  parameter int W       = 32,
  parameter int F       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  fx_div_seq_if.slave  io
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e        state_q, state_d;
  logic [W-1:0]  num_abs_q, num_abs_d;
  logic [W-1:0]  inv_q, inv_d;
  logic [W-1:0]  recip_x_q, recip_x_d;
  logic [W-1:0]  quo_q, quo_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  num_mag, den_mag, mul_res;
  logic          den_bad;

  // |x| of the most negative value wraps to 2^(W-1), which is the desired unsigned magnitude.
  assign num_mag = io.num_in[W-1] ? -io.num_in : io.num_in;
  assign den_mag = io.den_in[W-1] ? -io.den_in : io.den_in;
  assign den_bad = (io.den_in == '0) || (io.den_in == {1'b1, {(W-1){1'b0}}});

  fx_sat_mul #(.W(W), .F(F)) u_sat_mul (
    .num_abs (num_abs_q),
    .inv     (inv_q),
    .neg     (neg_q),
    .result  (mul_res)
  );

  always_comb begin
    state_d   = state_q;
    num_abs_d = num_abs_q;
    inv_d     = inv_q;
    recip_x_d = recip_x_q;
    quo_d     = quo_q;
    neg_d     = neg_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: if (io.in_valid) begin
        num_abs_d = num_mag;
        neg_d     = io.num_in[W-1] ^ io.den_in[W-1];
        recip_x_d = den_mag;
        quo_d     = '0;
        err_d     = den_bad;
        state_d   = den_bad ? ST_OUT : ST_REQ;
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // done takes priority over a timeout landing in the same cycle
        if (io.recip_done) begin
          if (io.recip_invalid) begin
            err_d   = 1'b1;
            state_d = ST_OUT;
          end else begin
            inv_d   = io.recip_inv;
            state_d = ST_MUL;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_MUL: begin
        quo_d   = mul_res;
        err_d   = 1'b0;
        state_d = ST_OUT;
      end
      ST_OUT: if (io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      num_abs_q <= '0;
      inv_q     <= '0;
      recip_x_q <= '0;
      quo_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_abs_q <= num_abs_d;
      inv_q     <= inv_d;
      recip_x_q <= recip_x_d;
      quo_q     <= quo_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign io.in_ready    = (state_q == ST_IDLE);
  assign io.out_valid   = (state_q == ST_OUT);
  assign io.recip_start = (state_q == ST_REQ);
  assign io.recip_x     = recip_x_q;
  assign io.quo_out     = quo_q;
  assign io.out_err     = err_q;
endmodule

// File: tb/tb_fx_div_seq.sv
// Directed bench for fx_div_seq: a reciprocal responder, an arithmetic quotient model
// checked every valid cycle (value and latency), plus literal expectations per vector.
module tb_fx_div_seq;
  import fx_pkg::*;

  localparam int W       = 32;
  localparam int F       = 16;
  localparam int TIMEOUT = 64;

  typedef enum {K_NORM, K_INV, K_SPEC, K_TMO} kind_e;
  typedef struct {
    logic [31:0] quo;
    logic        err;
    kind_e       kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fx_div_seq_if #(.W(W)) io();

  fx_div_seq #(.W(W), .F(F), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          starts = 0;
  int          acc_cyc  = -1000;
  int          done_cyc = -1000;
  logic        prev_valid = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] exp_x = '0;
  int          resp_delay = 10;
  logic [31:0] resp_inv = '0;
  logic        resp_invalid = 1'b0;
  logic        resp_on = 1'b1;
  logic        chk_hold = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Quotient from plain signed arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] num, input logic [31:0] den,
                                 input logic [31:0] inv, input logic invalid,
                                 input logic timeout);
    exp_t        e;
    longint      sn;
    logic [63:0] na, p, q;
    logic        neg;
    e.quo  = '0;
    e.err  = 1'b1;
    e.kind = K_SPEC;
    if (den == 32'h0 || den == 32'h8000_0000) return e;
    e.kind = K_TMO;
    if (timeout) return e;
    e.kind = K_INV;
    if (invalid) return e;
    e.kind = K_NORM;
    e.err  = 1'b0;
    sn  = longint'($signed(num));
    na  = (sn < 0) ? 64'(-sn) : 64'(sn);
    neg = num[31] ^ den[31];
    p   = na * {32'h0, inv};
    q   = p >> F;
    if (!neg) e.quo = (q > 64'h7FFF_FFFF) ? Q_MAX_POS : q[31:0];
    else      e.quo = (q > 64'h8000_0000) ? Q_MIN_NEG : -q[31:0];
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: value, stability and latency against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (io.recip_start) starts++;
      if (io.in_valid && io.in_ready) acc_cyc = cyc;
      if (io.recip_done) done_cyc = cyc;
      if (io.out_valid) begin
        chk("in_ready_while_out", io.in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", io.out_valid, 0);
        end else begin
          if (!prev_valid) begin
            case (exp_q[0].kind)
              K_NORM:  chk("lat_after_done", cyc, done_cyc + 2);
              K_INV:   chk("lat_after_invalid", cyc, done_cyc + 1);
              K_SPEC:  chk("lat_special", cyc, acc_cyc + 1);
              default: chk("lat_timeout", cyc, acc_cyc + 2 + TIMEOUT);
            endcase
          end
          chk("model_quo", io.quo_out, exp_q[0].quo);
          chk("model_err", io.out_err, exp_q[0].err);
          if (io.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = io.out_valid;
    end
  end

  // Reciprocal responder: answers each start after resp_delay cycles.
  initial begin
    io.recip_done    = 1'b0;
    io.recip_inv     = '0;
    io.recip_invalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && io.recip_start) begin
        chk("recip_x", io.recip_x, exp_x);
        if (resp_on) begin
          repeat (resp_delay) @(posedge clk);
          #1;
          io.recip_done    = 1'b1;
          io.recip_inv     = resp_inv;
          io.recip_invalid = resp_invalid;
          if (chk_hold) chk("recip_x_hold", io.recip_x, exp_x);
          @(posedge clk);
          #1;
          io.recip_done    = 1'b0;
          io.recip_invalid = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] num, input logic [31:0] den,
                        input logic [31:0] inv, input int delay, input logic invalid,
                        input logic nodone, input int hold,
                        output logic [31:0] quo, output logic err);
    exp_t   e;
    int     s0;
    bit     got;
    longint sd;
    e  = model(num, den, inv, invalid, nodone);
    exp_q.push_back(e);
    sd = longint'($signed(den));
    exp_x        = (sd < 0) ? 32'(-sd) : 32'(sd);
    resp_delay   = delay;
    resp_inv     = inv;
    resp_invalid = invalid;
    resp_on      = !nodone;
    s0           = starts;
    io.out_ready = (hold == 0);
    io.num_in    = num;
    io.den_in    = den;
    io.in_valid  = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (io.out_valid) got = 1;
    end
    if (!got) chk("out_valid_wait", io.out_valid, 1);
    quo = io.quo_out;
    err = io.out_err;
    chk("start_pulses", starts - s0, (e.kind == K_SPEC) ? 0 : 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_quo", io.quo_out, quo);
      chk("hold_valid", io.out_valid, 1);
      chk("hold_in_ready", io.in_ready, 0);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1 io.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!got) exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic        e;
    io.in_valid  = 1'b0;
    io.num_in    = '0;
    io.den_in    = '0;
    io.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_err", io.out_err, 0);
    chk("rst_quo", io.quo_out, 0);
    chk("rst_recip_start", io.recip_start, 0);
    chk("rst_recip_x", io.recip_x, 0);
    @(posedge clk);
    #1;

    run_op(32'h0006_0000, 32'h0002_0000, 32'h0000_8000, 10, 0, 0, 0, q, e);
    chk("t1_quo", q, 32'h0003_0000);  chk("t1_err", e, 0);
    run_op(32'hFFFD_0000, 32'hFFFF_8000, 32'h0002_0000, 4, 0, 0, 0, q, e);
    chk("t2a_quo", q, 32'h0006_0000); chk("t2a_err", e, 0);
    run_op(32'h0003_0000, 32'hFFFF_8000, 32'h0002_0000, 4, 0, 0, 0, q, e);
    chk("t2b_quo", q, 32'hFFFA_0000);
    run_op(32'h0001_0000, 32'h0000_0000, 32'h0, 1, 0, 0, 0, q, e);
    chk("t3a_quo", q, 32'h0);         chk("t3a_err", e, 1);
    run_op(32'h0001_0000, 32'h8000_0000, 32'h0, 1, 0, 0, 0, q, e);
    chk("t3b_quo", q, 32'h0);         chk("t3b_err", e, 1);
    run_op(32'h4000_0000, 32'h0000_0100, 32'h0100_0000, 3, 0, 0, 0, q, e);
    chk("t4a_quo", q, 32'h7FFF_FFFF); chk("t4a_err", e, 0);
    run_op(32'hC000_0000, 32'h0000_0100, 32'h0100_0000, 3, 0, 0, 0, q, e);
    chk("t4b_quo", q, 32'h8000_0000);
    run_op(32'h0001_0000, 32'h0003_0000, 32'h0, 1, 0, 1, 0, q, e);
    chk("t5a_quo", q, 32'h0);         chk("t5a_err", e, 1);
    run_op(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 2, 1, 0, 0, q, e);
    chk("t5b_quo", q, 32'h0);         chk("t5b_err", e, 1);
    run_op(32'h0005_0000, 32'h0001_0000, 32'h0001_0000, 1, 0, 0, 5, q, e);
    chk("t6_quo", q, 32'h0005_0000);
    run_op(32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 1, 0, 0, 0, q, e);
    chk("min_exact_quo", q, 32'h8000_0000); chk("min_exact_err", e, 0);
    run_op(32'h0000_0000, 32'hFFFF_0000, 32'h0001_0000, 2, 0, 0, 0, q, e);
    chk("zero_quo", q, 32'h0);
    run_op(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 2, 0, 0, 0, q, e);
    chk("trunc_pos_quo", q, 32'h0000_5555);
    run_op(32'hFFFF_0000, 32'h0003_0000, 32'h0000_5555, 2, 0, 0, 0, q, e);
    chk("trunc_neg_quo", q, 32'hFFFF_AAAB);

    // Reset while waiting for the reciprocal; its late done must be ignored.
    chk_hold     = 1'b0;
    exp_x        = 32'h0002_0000;
    resp_delay   = 10;
    resp_inv     = 32'h0000_8000;
    resp_invalid = 1'b0;
    resp_on      = 1'b1;
    io.num_in    = 32'h0006_0000;
    io.den_in    = 32'h0002_0000;
    io.in_valid  = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wrst_in_ready", io.in_ready, 1);
    chk("wrst_out_valid", io.out_valid, 0);
    chk("wrst_recip_x", io.recip_x, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("wrst_idle_valid", io.out_valid, 0);
      chk("wrst_idle_ready", io.in_ready, 1);
    end
    chk_hold = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fx_div_seq.md
Name: fx_div_seq

Overview:
- Initiator-side sequencer that drives the fixed-point reciprocal unit and turns its result into a signed Q(W-F).F quotient num/den = num * (1/den).
- Accepts operand pairs on a valid/ready input and handles sign and special cases.
- Issues start/operand to the reciprocal responder, waits for done, multiplies, saturates.
- Returns the result on a valid/ready output; sits between the control datapath and the reciprocal unit.

Parameters:
W, 32, total word width (signed fixed point)
F, 16, fraction bits (QF format, same as the reciprocal unit)
TIMEOUT, 64, max cycles waiting for recip_done before flagging error

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
num_in  input  W  signed QF numerator
den_in  input  W  signed QF denominator
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quo_out  output  W  signed QF quotient
out_err  output  1  result is an error (quo_out=0)
recip_start  output  1  one-cycle start pulse to reciprocal unit
recip_x  output  W  signed positive operand to reciprocal unit
recip_done  input  1  reciprocal result valid (one cycle)
recip_inv  input  W  unsigned QF reciprocal
recip_invalid  input  1  reciprocal rejected operand

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst: state IDLE, in_ready=1, out_valid=0, out_err=0, quo_out=0, recip_start=0, recip_x=0, timeout counter=0. This applies in any state, including mid-WAIT; the unit then ignores any late recip_done.
- States: IDLE, REQ, WAIT, MUL, OUT.
- IDLE: in_ready=1. When in_valid is high:
  - latch num_abs=|num_in| as an unsigned W-bit value; num=-2^(W-1) gives 2^(W-1).
  - latch neg = num_in[W-1] XOR den_in[W-1].
  - latch den_abs=|den_in|.
  - if den_in==0 or den_in==-2^(W-1): set err, go to OUT; no recip_start.
  - else go to REQ.
- REQ: recip_start=1 for exactly this cycle; recip_x=den_abs. Clear timeout counter. Go to WAIT.
- WAIT: recip_x is held stable; the counter increments each cycle.
  - recip_done=1 and recip_invalid=1: err, go to OUT.
  - recip_done=1 and recip_invalid=0: capture recip_inv, go to MUL.
  - counter reaches TIMEOUT-1 without done: err, go to OUT.
  - if done and timeout occur in the same cycle, done wins.
- recip_done in any state other than WAIT is ignored.
- MUL: p = num_abs * inv, an unsigned 2W-bit product, then q = p >> F (truncation toward zero on the magnitude).
  - neg=0: result = q if q <= 2^(W-1)-1, else saturate to 0x7FFF_FFFF.
  - neg=1: result = -q if q <= 2^(W-1), else saturate to 0x8000_0000.
  - a zero result is never negative-signed.
  - go to OUT.
- OUT: out_valid=1; quo_out and out_err are stable until handshake. When out_ready=1: go to IDLE, out_valid=0 next cycle. in_ready=0 in every state except IDLE.
- Error result: quo_out=0, out_err=1.
- Latency:
  - out_valid rises 2 cycles after the cycle in which recip_done is sampled high.
  - for den==0, out_valid rises the cycle after acceptance.
- Single outstanding request; no pipelining.

Decomposition:
- Package fx_pkg: state enum (logic [2:0]); QF constants Q_MAX_POS and Q_MIN_NEG; function sat_signed(mag, neg).
- Sub-module fx_sat_mul: combinational multiply/shift/saturate for the MUL state (num_abs, inv, neg -> result). Its output is registered in fx_div_seq.

Test Plan:
1. num=0x0006_0000 (6.0), den=0x0002_0000; model returns recip_inv=0x0000_8000 after 10 cycles -> one recip_start pulse, recip_x=0x0002_0000, quo_out=0x0003_0000, out_err=0, out_valid 2 cycles after done.
2. num=0xFFFD_0000 (-3.0), den=0xFFFF_8000 (-0.5); model returns 0x0002_0000 -> recip_x=0x0000_8000, quo_out=0x0006_0000. Then num=0x0003_0000, den=0xFFFF_8000 -> quo_out=0xFFFA_0000.
3. den=0x0000_0000, num=0x0001_0000 -> no recip_start, out_valid the next cycle, out_err=1, quo_out=0. Same for den=0x8000_0000.
4. num=0x4000_0000, den=0x0000_0100, model recip_inv=0x0100_0000 -> quo_out=0x7FFF_FFFF. Negative num=0xC000_0000 -> quo_out=0x8000_0000.
5. Model never asserts done -> after TIMEOUT cycles in WAIT, out_err=1, quo_out=0. recip_invalid=1 with done -> out_err=1.
6. out_ready held low 5 cycles -> quo_out stable, in_ready=0. Separately, rst pulsed in WAIT, then recip_done arrives -> out_valid stays 0, in_ready=1 the cycle after reset.
